// File: rtl/tlb_op_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tlb_op_ctrl
// Brief    : Sequences TLBP/TLBR/TLBWI retiring at writeback and arbitrates the
//            shared TLB search port s1 between TLBP and the data-side lookup.
// Revision : 1.0 - initial release
// ============================================================================
module tlb_op_ctrl #(
    parameter int TLBNUM = 16,
    parameter int IDX_W  = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [1:0]       op_type,
    input  logic [31:0]      op_pc,
    input  logic             abort,
    input  logic [31:0]      cp0_index,
    input  logic [31:0]      cp0_entryhi,
    input  logic [31:0]      cp0_entrylo0,
    input  logic [31:0]      cp0_entrylo1,
    input  logic             ds_req,
    input  logic [18:0]      ds_vpn2,
    input  logic [7:0]       ds_asid,
    output logic             ds_grant,
    output logic [18:0]      s1_vpn2,
    output logic [7:0]       s1_asid,
    input  logic             s1_found,
    input  logic [IDX_W-1:0] s1_index,
    output logic [IDX_W-1:0] r_index,
    input  logic [77:0]      r_entry,
    output logic             we,
    output logic [IDX_W-1:0] w_index,
    output logic [77:0]      w_entry,
    output logic             tlbr_we,
    output logic [77:0]      tlbr_data,
    output logic             tlbp_we,
    output logic             tlbp_miss,
    output logic [IDX_W-1:0] tlbp_index,
    output logic             flush_req,
    output logic [31:0]      flush_pc,
    output logic             busy
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_SRCH  = 3'd1;
    localparam logic [2:0] c_RD    = 3'd2;
    localparam logic [2:0] c_WR    = 3'd3;
    localparam logic [2:0] c_FLUSH = 3'd4;

    generate
        if (TLBNUM != (1 << IDX_W)) begin : g_cfg_err
            $error("tlb_op_ctrl: TLBNUM must equal 2**IDX_W");
        end
    endgenerate

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic             w_accept;
    logic             w_srch;
    logic [77:0]      w_pack;
    logic [31:0]      r_op_pc;
    logic [IDX_W-1:0] r_op_idx;
    logic [77:0]      r_wr_entry;
    logic             r_tlbp_we;
    logic             r_tlbp_miss;
    logic [IDX_W-1:0] r_tlbp_index;
    logic             r_tlbr_we;
    logic [77:0]      r_tlbr_data;
    logic             r_flush_req;
    logic [31:0]      r_flush_pc;
    logic             w_unused;

    assign w_unused = ^{cp0_index[31:IDX_W], cp0_entryhi[12:8],
                        cp0_entrylo0[31:26], cp0_entrylo1[31:26]};

    // The snapshot holds the full entry; its vpn2/asid fields double as the TLBP key.
    assign w_pack = {cp0_entryhi[31:13], cp0_entryhi[7:0],
                     cp0_entrylo0[0] & cp0_entrylo1[0],
                     cp0_entrylo0[25:6], cp0_entrylo0[5:3], cp0_entrylo0[2], cp0_entrylo0[1],
                     cp0_entrylo1[25:6], cp0_entrylo1[5:3], cp0_entrylo1[2], cp0_entrylo1[1]};

    assign w_accept = (r_state == c_IDLE) & op_valid & ~abort;
    assign w_srch   = (r_state == c_SRCH);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    case (op_type)
                        2'b01:   w_state_nxt = c_SRCH;
                        2'b10:   w_state_nxt = c_RD;
                        2'b11:   w_state_nxt = c_WR;
                        default: w_state_nxt = c_IDLE;
                    endcase
                end
            end
            c_SRCH:  w_state_nxt = c_IDLE;
            c_RD:    w_state_nxt = abort ? c_IDLE : c_FLUSH;
            c_WR:    w_state_nxt = c_FLUSH;
            c_FLUSH: w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= c_IDLE;
            r_op_pc      <= '0;
            r_op_idx     <= '0;
            r_wr_entry   <= '0;
            r_tlbp_we    <= 1'b0;
            r_tlbp_miss  <= 1'b0;
            r_tlbp_index <= '0;
            r_tlbr_we    <= 1'b0;
            r_tlbr_data  <= '0;
            r_flush_req  <= 1'b0;
            r_flush_pc   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_tlbp_we   <= 1'b0;
            r_tlbr_we   <= 1'b0;
            r_flush_req <= 1'b0;
            if (w_accept) begin
                r_op_pc    <= op_pc;
                r_op_idx   <= cp0_index[IDX_W-1:0];
                r_wr_entry <= w_pack;
            end
            case (r_state)
                c_SRCH: begin
                    if (!abort) begin
                        r_tlbp_we    <= 1'b1;
                        r_tlbp_miss  <= ~s1_found;
                        r_tlbp_index <= s1_index;
                    end
                end
                c_RD: begin
                    if (!abort) begin
                        r_tlbr_we   <= 1'b1;
                        r_tlbr_data <= r_entry;
                        r_flush_req <= 1'b1;
                        r_flush_pc  <= r_op_pc + 32'd4;
                    end
                end
                // The write has already been issued, so abort cannot cancel the refetch.
                c_WR: begin
                    r_flush_req <= 1'b1;
                    r_flush_pc  <= r_op_pc + 32'd4;
                end
                default: ;
            endcase
        end
    end

    assign op_ready   = (r_state == c_IDLE);
    assign busy       = (r_state != c_IDLE);
    assign ds_grant   = ds_req & ~w_srch;
    assign s1_vpn2    = w_srch ? r_wr_entry[77:59] : ds_vpn2;
    assign s1_asid    = w_srch ? r_wr_entry[58:51] : ds_asid;
    assign r_index    = r_op_idx;
    assign we         = (r_state == c_WR);
    assign w_index    = r_op_idx;
    assign w_entry    = r_wr_entry;
    assign tlbr_we    = r_tlbr_we;
    assign tlbr_data  = r_tlbr_data;
    assign tlbp_we    = r_tlbp_we;
    assign tlbp_miss  = r_tlbp_miss;
    assign tlbp_index = r_tlbp_index;
    assign flush_req  = r_flush_req;
    assign flush_pc   = r_flush_pc;

endmodule
`default_nettype wire
